// File: rtl/adc_serial_reader_if.sv
// Bus between the ADC sequencer/reader and its surroundings: ADC pins, scan control
// and the packed per-channel result bus.
interface adc_serial_reader_if;
    logic         enable;
    logic [15:0]  channelmask;
    logic         sdo;
    logic         cnv;
    logic         sck;
    logic [3:0]   muxaddr;
    logic [255:0] adcdata;
    logic [15:0]  adcready;
    logic         busy;

    modport master (
        input  enable, channelmask, sdo,
        output cnv, sck, muxaddr, adcdata, adcready, busy
    );

    modport slave (
        output enable, channelmask, sdo,
        input  cnv, sck, muxaddr, adcdata, adcready, busy
    );
endinterface

// File: rtl/adc_serial_reader.sv
// Multiplexed 16-channel ADC sequencer and serial reader.
// Optional macro ADCREADER_OFFSET_BINARY_EN: store results as offset binary (bit 15 inverted).
//
// state   | meaning
// IDLE    | waiting for enable with a nonzero channel mask
// SETTLE  | mux address applied, analog input settling
// CONVERT | cnv high, conversion in progress
// SHIFT   | 16 sck periods, sdo shifted in MSB first
// DONE    | result stored, adcready strobe, next channel chosen
module adc_serial_reader #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 200,
    parameter int SETTLE_CYCLES = 16
) (
    input logic                 clk,
    input logic                 sclr,
    adc_serial_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, SHIFT, DONE} state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CONV_LOAD   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] HALF_LOAD   = 16'(CLK_DIV - 1);

    state_t         state;
    logic [15:0]    cnt;
    logic [3:0]     bitcnt;
    logic [15:0]    shreg;
    logic           cnv_q;
    logic           sck_q;
    logic           busy_q;
    logic [3:0]     muxaddr_q;
    logic [255:0]   adcdata_q;
    logic [15:0]    adcready_q;

    logic [15:0]    result;
    logic [3:0]     first_ch;
    logic [3:0]     next_ch;
    logic           scan_start;

    // Lowest set mask bit at or above start, wrapping 15 -> 0.
    function automatic logic [3:0] find_from(input logic [15:0] mask, input logic [3:0] start);
        logic [3:0] idx;
        logic [3:0] sel;
        logic       found;
        sel   = start;
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        first_ch   = find_from(bus.channelmask, muxaddr_q);
        next_ch    = find_from(bus.channelmask, muxaddr_q + 4'd1);
        scan_start = bus.enable && (bus.channelmask != 16'd0);
`ifdef ADCREADER_OFFSET_BINARY_EN
        result     = {~shreg[15], shreg[14:0]};
`else
        result     = shreg;
`endif
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            cnv_q      <= 1'b0;
            sck_q      <= 1'b0;
            busy_q     <= 1'b0;
            muxaddr_q  <= '0;
            adcdata_q  <= '0;
            adcready_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    adcready_q <= '0;
                    if (scan_start) begin
                        state     <= SETTLE;
                        muxaddr_q <= first_ch;
                        cnt       <= SETTLE_LOAD;
                        busy_q    <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == 16'd0) begin
                        state <= CONVERT;
                        cnv_q <= 1'b1;
                        cnt   <= CONV_LOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CONVERT: begin
                    if (cnt == 16'd0) begin
                        state  <= SHIFT;
                        cnv_q  <= 1'b0;
                        sck_q  <= 1'b0;
                        bitcnt <= '0;
                        cnt    <= HALF_LOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (!sck_q) begin
                        // sdo is captured on the edge that raises sck
                        sck_q <= 1'b1;
                        shreg <= {shreg[14:0], bus.sdo};
                        cnt   <= HALF_LOAD;
                    end else begin
                        sck_q <= 1'b0;
                        if (bitcnt == 4'd15) begin
                            state                            <= DONE;
                            adcdata_q[{muxaddr_q, 4'b0} +: 16] <= result;
                            adcready_q                       <= 16'd1 << muxaddr_q;
                        end else begin
                            bitcnt <= bitcnt + 4'd1;
                            cnt    <= HALF_LOAD;
                        end
                    end
                end
                DONE: begin
                    adcready_q <= '0;
                    if (scan_start) begin
                        state     <= SETTLE;
                        muxaddr_q <= next_ch;
                        cnt       <= SETTLE_LOAD;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnv      = cnv_q;
    assign bus.sck      = sck_q;
    assign bus.muxaddr  = muxaddr_q;
    assign bus.adcdata  = adcdata_q;
    assign bus.adcready = adcready_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench for adc_serial_reader: ADC shift-register model plus a result scoreboard.
module tb_adc_serial_reader;
    localparam int CLK_DIV       = 2;
    localparam int CONV_CYCLES   = 10;
    localparam int SETTLE_CYCLES = 4;
    localparam int PERIOD        = SETTLE_CYCLES + CONV_CYCLES + 32 * CLK_DIV + 1;

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic sclr;

    adc_serial_reader_if bus();

    adc_serial_reader #(
        .CLK_DIV      (CLK_DIV),
        .CONV_CYCLES  (CONV_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk (clk),
        .sclr(sclr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    exp_t         sb[$];
    logic [15:0]  word_tab[16];
    logic [255:0] exp_all;
    logic [15:0]  sr = 16'd0;
    logic         sck_prev = 1'b0;
    int           cnv_cnt = 0;
    int           sck_rise = 0;

    // ADC model: loads the word for the selected channel during CNV, shifts after each sck rise
    always @(negedge clk) begin
        if (bus.cnv) sr = word_tab[bus.muxaddr];
        else if (bus.sck && !sck_prev) sr = sr << 1;
        if (bus.cnv) cnv_cnt++;
        if (bus.sck && !sck_prev) sck_rise++;
        sck_prev = bus.sck;
        bus.sdo  = sr[15];
    end

    function automatic logic [15:0] stored(input logic [15:0] w);
`ifdef ADCREADER_OFFSET_BINARY_EN
        return w ^ 16'h8000;
`else
        return w;
`endif
    endfunction

    task automatic do_reset();
        sclr            = 1'b1;
        bus.enable      = 1'b0;
        bus.channelmask = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        sclr    = 1'b0;
        exp_all = '0;
        sb.delete();
    endtask

    task automatic wait_ready(input int budget, output int k, output logic [15:0] rdy);
        k   = 0;
        rdy = 16'd0;
        while (k < budget && rdy == 16'd0) begin
            @(posedge clk);
            #1;
            k++;
            rdy = bus.adcready;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.cnv !== 1'b0) begin n_err++; $display("FAIL reset_cnv got %b want 0", bus.cnv); end
        n_cmp++; if (bus.sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got %b want 0", bus.sck); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.muxaddr !== 4'd0) begin n_err++; $display("FAIL reset_muxaddr got %0d want 0", bus.muxaddr); end
        n_cmp++; if (bus.adcready !== 16'd0) begin n_err++; $display("FAIL reset_adcready got %h want 0", bus.adcready); end
        n_cmp++; if (bus.adcdata !== 256'd0) begin n_err++; $display("FAIL reset_adcdata got nonzero want 0"); end
    endtask

    task automatic test_single();
        int k; logic [15:0] rdy; exp_t e; int cnv0, sck0;
        do_reset();
        word_tab[0] = 16'hA5C3;
        bus.channelmask = 16'h0001;
        bus.enable = 1'b1;
        cnv0 = cnv_cnt; sck0 = sck_rise;
        sb.push_back('{ch: 4'd0, data: stored(16'hA5C3)});
        sb.push_back('{ch: 4'd0, data: stored(16'hA5C3)});
        for (int r = 0; r < 2; r++) begin
            wait_ready(PERIOD + 20, k, rdy);
            if (rdy == 16'd0) begin
                n_cmp++; n_err++; $display("FAIL single_timeout round %0d no adcready", r);
            end else begin
                e = sb.pop_front();
                exp_all[e.ch*16 +: 16] = e.data;
                n_cmp++; if (k !== PERIOD) begin n_err++; $display("FAIL single_latency round %0d got %0d want %0d", r, k, PERIOD); end
                n_cmp++; if (rdy !== (16'd1 << e.ch)) begin n_err++; $display("FAIL single_ready got %h want %h", rdy, 16'd1 << e.ch); end
                n_cmp++; if (bus.adcdata !== exp_all) begin n_err++; $display("FAIL single_data got %h want %h", bus.adcdata[15:0], exp_all[15:0]); end
                if (r == 0) begin
                    n_cmp++; if (cnv_cnt - cnv0 !== CONV_CYCLES) begin n_err++; $display("FAIL single_cnv_cycles got %0d want %0d", cnv_cnt - cnv0, CONV_CYCLES); end
                    n_cmp++; if (sck_rise - sck0 !== 16) begin n_err++; $display("FAIL single_sck_edges got %0d want 16", sck_rise - sck0); end
                end
            end
        end
        bus.enable = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.adcready !== 16'd0) begin n_err++; $display("FAIL single_strobe_width got %h want 0", bus.adcready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        int k; logic [15:0] rdy; exp_t e;
        do_reset();
        word_tab[0]  = 16'h1111;
        word_tab[15] = 16'hFFFF;
        bus.channelmask = 16'h8001;
        bus.enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{ch: 4'd0,  data: stored(16'h1111)});
            sb.push_back('{ch: 4'd15, data: stored(16'hFFFF)});
        end
        for (int r = 0; r < 4; r++) begin
            wait_ready(PERIOD + 20, k, rdy);
            if (r == 3) bus.enable = 1'b0;
            if (rdy == 16'd0) begin
                n_cmp++; n_err++; $display("FAIL wrap_timeout round %0d no adcready", r);
            end else begin
                e = sb.pop_front();
                exp_all[e.ch*16 +: 16] = e.data;
                n_cmp++; if (k !== PERIOD) begin n_err++; $display("FAIL wrap_period round %0d got %0d want %0d", r, k, PERIOD); end
                n_cmp++; if (bus.muxaddr !== e.ch) begin n_err++; $display("FAIL wrap_muxaddr round %0d got %0d want %0d", r, bus.muxaddr, e.ch); end
                n_cmp++; if (rdy !== (16'd1 << e.ch)) begin n_err++; $display("FAIL wrap_ready got %h want %h", rdy, 16'd1 << e.ch); end
                n_cmp++; if (bus.adcdata !== exp_all) begin n_err++; $display("FAIL wrap_data ch0 %h ch15 %h want %h %h", bus.adcdata[15:0], bus.adcdata[255:240], exp_all[15:0], exp_all[255:240]); end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wrap_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_empty();
        logic bad;
        do_reset();
        bus.channelmask = 16'h0000;
        bus.enable = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.cnv || bus.sck || (bus.adcready != 16'd0)) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL empty_mask_activity got %b want 0", bad); end
        bus.enable = 1'b0;
    endtask

    task automatic test_stop();
        int k; logic [15:0] rdy; exp_t e; int w;
        do_reset();
        word_tab[3] = 16'h3C5A;
        bus.channelmask = 16'h0008;
        bus.enable = 1'b1;
        sb.push_back('{ch: 4'd3, data: stored(16'h3C5A)});
        w = 0;
        while (w < 50 && bus.cnv !== 1'b1) begin @(posedge clk); #1; w++; end
        n_cmp++; if (bus.cnv !== 1'b1) begin n_err++; $display("FAIL stop_cnv_timeout got %b want 1", bus.cnv); end
        bus.enable = 1'b0;
        wait_ready(PERIOD + 20, k, rdy);
        if (rdy == 16'd0) begin
            n_cmp++; n_err++; $display("FAIL stop_timeout no adcready for channel 3");
        end else begin
            e = sb.pop_front();
            exp_all[e.ch*16 +: 16] = e.data;
            n_cmp++; if (rdy !== 16'h0008) begin n_err++; $display("FAIL stop_ready got %h want 0008", rdy); end
            n_cmp++; if (bus.adcdata !== exp_all) begin n_err++; $display("FAIL stop_data got %h want %h", bus.adcdata[63:48], exp_all[63:48]); end
        end
        wait_ready(2 * PERIOD, k, rdy);
        n_cmp++; if (rdy !== 16'd0) begin n_err++; $display("FAIL stop_extra_ready got %h want 0", rdy); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_sclr_midshift();
        int k; logic [15:0] rdy; exp_t e; int s0; int w;
        do_reset();
        word_tab[0] = 16'h1234;
        bus.channelmask = 16'h0001;
        bus.enable = 1'b1;
        sb.push_back('{ch: 4'd0, data: stored(16'h1234)});
        wait_ready(PERIOD + 20, k, rdy);
        if (rdy == 16'd0) begin
            n_cmp++; n_err++; $display("FAIL sclr_first_timeout no adcready");
        end else begin
            e = sb.pop_front();
            exp_all[e.ch*16 +: 16] = e.data;
            n_cmp++; if (bus.adcdata !== exp_all) begin n_err++; $display("FAIL sclr_first_data got %h want %h", bus.adcdata[15:0], exp_all[15:0]); end
        end
        s0 = sck_rise;
        w = 0;
        while (w < 2 * PERIOD && sck_rise - s0 < 8) begin @(posedge clk); #1; w++; end
        n_cmp++; if (sck_rise - s0 !== 8) begin n_err++; $display("FAIL sclr_sck_edges got %0d want 8", sck_rise - s0); end
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        bus.enable = 1'b0;
        n_cmp++; if (bus.cnv !== 1'b0 || bus.sck !== 1'b0) begin n_err++; $display("FAIL sclr_pins got cnv %b sck %b want 0 0", bus.cnv, bus.sck); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sclr_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.adcdata !== 256'd0) begin n_err++; $display("FAIL sclr_adcdata got %h want 0", bus.adcdata[15:0]); end
        wait_ready(2 * PERIOD, k, rdy);
        n_cmp++; if (rdy !== 16'd0) begin n_err++; $display("FAIL sclr_aborted_ready got %h want 0", rdy); end
    endtask

    task automatic test_offset();
        int k; logic [15:0] rdy; exp_t e;
        do_reset();
        word_tab[1] = 16'h8000;
        word_tab[2] = 16'h7FFF;
        bus.channelmask = 16'h0006;
        bus.enable = 1'b1;
        sb.push_back('{ch: 4'd1, data: stored(16'h8000)});
        sb.push_back('{ch: 4'd2, data: stored(16'h7FFF)});
        for (int r = 0; r < 2; r++) begin
            wait_ready(PERIOD + 20, k, rdy);
            if (r == 1) bus.enable = 1'b0;
            if (rdy == 16'd0) begin
                n_cmp++; n_err++; $display("FAIL offset_timeout round %0d no adcready", r);
            end else begin
                e = sb.pop_front();
                exp_all[e.ch*16 +: 16] = e.data;
                n_cmp++; if (rdy !== (16'd1 << e.ch)) begin n_err++; $display("FAIL offset_ready got %h want %h", rdy, 16'd1 << e.ch); end
                n_cmp++; if (bus.adcdata !== exp_all) begin n_err++; $display("FAIL offset_data ch1 %h ch2 %h want %h %h", bus.adcdata[31:16], bus.adcdata[47:32], exp_all[31:16], exp_all[47:32]); end
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) word_tab[i] = 16'd0;
        bus.sdo = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_empty();
        test_stop();
        test_sclr_midshift();
        test_offset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
